// File: rtl/button_autorepeat.sv
// ============================================================================
// Module   : button_autorepeat
// Brief    : Turns a synchronized button level into one-cycle move pulses with
//            an initial pulse, a hold-off delay and a fixed auto-repeat rate.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module button_autorepeat #(
    parameter int DELAY_CYCLES  = 16,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic b,
    output logic out,
    output logic rep
);

    localparam int c_MAX_CYCLES = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(DELAY_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REPEAT_LAST = c_CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;
    logic               out_q,   out_d;
    logic               rep_q,   rep_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rep_q   <= rep_d;
        end
    end

    // Release is checked first so it beats a terminal count on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;

        if (!b) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_DELAY;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                end
                S_DELAY: begin
                    if (cnt_q == c_DELAY_LAST) begin
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                        out_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + c_CNT_ONE;
                    end
                end
                S_REPEAT: begin
                    if (cnt_q == c_REPEAT_LAST) begin
                        cnt_d   = '0;
                        out_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + c_CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        rep_d = (state_d == S_REPEAT);
    end

    assign out = out_q;
    assign rep = rep_q;

endmodule

`default_nettype wire

// File: tb/tb_button_autorepeat.sv
// ============================================================================
// Module   : tb_button_autorepeat
// Brief    : Self-checking bench for button_autorepeat at (4,2) and (1,1).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_autorepeat;

    localparam int c_DA = 4;
    localparam int c_RA = 2;
    localparam int c_DB = 1;
    localparam int c_RB = 1;

    logic clk;
    logic reset;
    logic b;
    logic out_a, rep_a;
    logic out_b, rep_b;

    int n_cmp;
    int n_bad;

    button_autorepeat #(.DELAY_CYCLES(c_DA), .REPEAT_CYCLES(c_RA)) dut_a (
        .clk   (clk),
        .reset (reset),
        .b     (b),
        .out   (out_a),
        .rep   (rep_a)
    );

    button_autorepeat #(.DELAY_CYCLES(c_DB), .REPEAT_CYCLES(c_RB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .b     (b),
        .out   (out_b),
        .rep   (rep_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: h counts edges since the press was first sampled.
    // A pulse is due at h==0 and at h==D+n*R; repeat mode is h>=D.
    function automatic logic pulse_due(input int h, input int d, input int r);
        return (h == 0) || (h >= d && ((h - d) % r) == 0);
    endfunction

    bit   m_valid;
    bit   m_held;
    int   m_h;
    logic m_out_a, m_rep_a, m_out_b, m_rep_b;

    initial begin
        m_valid = 1'b0;
        m_held  = 1'b0;
        m_h     = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_held  = 1'b0;
            m_out_a = 1'b0; m_rep_a = 1'b0;
            m_out_b = 1'b0; m_rep_b = 1'b0;
        end else if (!b) begin
            m_held  = 1'b0;
            m_out_a = 1'b0; m_rep_a = 1'b0;
            m_out_b = 1'b0; m_rep_b = 1'b0;
        end else begin
            m_h     = m_held ? m_h + 1 : 0;
            m_held  = 1'b1;
            m_out_a = pulse_due(m_h, c_DA, c_RA);
            m_rep_a = (m_h >= c_DA);
            m_out_b = pulse_due(m_h, c_DB, c_RB);
            m_rep_b = (m_h >= c_DB);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model out_a", out_a, m_out_a);
            chk("model rep_a", rep_a, m_rep_a);
            chk("model out_b", out_b, m_out_b);
            chk("model rep_b", rep_b, m_rep_b);
        end
    end

    task automatic step(input logic bv, input logic rv);
        b     = bv;
        reset = rv;
        @(posedge clk);
        #1;
    endtask

    logic [12:0] hold_out_exp;
    logic [12:0] hold_rep_exp;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        b     = 1'b1;
        reset = 1'b1;
        hold_out_exp = 13'b0010101010001;
        hold_rep_exp = 13'b0111111110000;

        // Reset held two cycles with the button down, then released.
        step(1'b1, 1'b1);
        chk("rst1 out_a", out_a, 1'b0); chk("rst1 rep_a", rep_a, 1'b0);
        step(1'b1, 1'b1);
        chk("rst2 out_a", out_a, 1'b0); chk("rst2 rep_b", rep_b, 1'b0);
        step(1'b1, 1'b0);
        chk("post-rst out_a", out_a, 1'b1);
        step(1'b1, 1'b0);
        chk("post-rst+1 out_a", out_a, 1'b0);
        chk("post-rst+1 out_b", out_b, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Tap: a single sampled high edge.
        step(1'b1, 1'b0);
        chk("tap out_a", out_a, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            chk("tap tail out_a", out_a, 1'b0);
            chk("tap tail rep_a", rep_a, 1'b0);
        end

        // Hold through edge 11, release at edge 12.
        for (int e = 0; e <= 12; e++) begin
            step((e <= 11) ? 1'b1 : 1'b0, 1'b0);
            chk("hold out_a", out_a, hold_out_exp[e]);
            chk("hold rep_a", rep_a, hold_rep_exp[e]);
        end
        step(1'b0, 1'b0);

        // Release on the same edge as a terminal count.
        for (int e = 0; e <= 6; e++) begin
            step((e <= 5) ? 1'b1 : 1'b0, 1'b0);
            if (e == 0 || e == 4) chk("relterm pulse", out_a, 1'b1);
            if (e == 6) begin
                chk("relterm out_a", out_a, 1'b0);
                chk("relterm rep_a", rep_a, 1'b0);
            end
        end
        step(1'b0, 1'b0);

        // Reset in the middle of repeat with the button held.
        for (int e = 0; e <= 13; e++) begin
            step(1'b1, (e == 7) ? 1'b1 : 1'b0);
            if (e == 6)  chk("midrst in repeat", rep_a, 1'b1);
            if (e == 7) begin
                chk("midrst out_a", out_a, 1'b0);
                chk("midrst rep_a", rep_a, 1'b0);
            end
            if (e == 8)  chk("midrst new press", out_a, 1'b1);
            if (e >= 9 && e <= 11) chk("midrst gap", out_a, 1'b0);
            if (e == 12) chk("midrst 2nd pulse", out_a, 1'b1);
        end
        step(1'b0, 1'b0);

        // Minimum parameters: continuous pulses while held.
        for (int e = 0; e < 5; e++) begin
            step(1'b1, 1'b0);
            chk("min out_b", out_b, 1'b1);
        end
        step(1'b0, 1'b0);
        chk("min release out_b", out_b, 1'b0);
        chk("min release rep_b", rep_b, 1'b0);

        // One-cycle gap re-press and a mixed pattern, checked by the model.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("repress out_a", out_a, 1'b1);
        for (int e = 0; e < 20; e++) step(((e % 7) != 6) ? 1'b1 : 1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
